// File: rtl/dm_cache_mem_system.sv
// Direct-mapped, write-back, write-allocate cache (256 lines x 4 words) in front of
// a 4-bank word-interleaved main memory model with 2-cycle read latency.
module dm_cache_mem_system (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        createdump,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err
);

   // Tag compare happens at acceptance, so a hit goes straight to DONE.
   typedef enum logic [2:0] {
      S_IDLE, S_WRITEBACK, S_ALLOC, S_ALLOC_WAIT, S_DONE
   } state_t;

   state_t      state;
   logic [15:0] main_mem [0:32767];
   logic [4:0]  tag_ram  [0:255];
   logic [15:0] data_ram [0:1023];
   logic [255:0] valid, dirty;

   logic [4:0]  req_tag;
   logic [7:0]  req_idx;
   logic [1:0]  req_word;
   logic [15:0] req_data;
   logic        req_wr;
   logic [1:0]  cnt;

   // Two-stage read pipeline models the bank read latency.
   logic        p1_v, p2_v;
   logic [1:0]  p1_word, p2_word;
   logic [15:0] p1_data, p2_data;

   logic [4:0]  in_tag;
   logic [7:0]  in_idx;
   logic [1:0]  in_word;
   logic        legal_req, accept, lookup_hit, fill_done, tag_we;
   logic [15:0] lookup_word;
   logic        mem_we;
   logic [14:0] mem_waddr, mem_raddr;
   logic [15:0] mem_wdata;
   logic        cache_we;
   logic [9:0]  cache_addr;
   logic [15:0] cache_wdata;
   logic        unused_createdump;

   assign unused_createdump = createdump;

   assign in_tag      = Addr[15:11];
   assign in_idx      = Addr[10:3];
   assign in_word     = Addr[2:1];
   assign legal_req   = (Rd ^ Wr) & ~Addr[0];
   assign err         = ~rst & ((Rd & Wr) | ((Rd | Wr) & Addr[0]));
   assign accept      = legal_req & ~Stall;
   assign lookup_hit  = valid[in_idx] & (tag_ram[in_idx] == in_tag);
   assign lookup_word = data_ram[{in_idx, in_word}];
   assign fill_done   = (state == S_ALLOC_WAIT) & ~p1_v & ~p2_v;
   assign tag_we      = fill_done & ~rst;
   assign mem_raddr   = {req_tag, req_idx, cnt};

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      mem_we      = 1'b0;
      mem_waddr   = {tag_ram[req_idx], req_idx, cnt};
      mem_wdata   = data_ram[{req_idx, cnt}];
      cache_we    = 1'b0;
      cache_addr  = {req_idx, req_word};
      cache_wdata = req_data;
      if (state == S_WRITEBACK && !rst) mem_we = 1'b1;
      if (accept && lookup_hit && Wr) begin
         cache_we    = 1'b1;
         cache_addr  = {in_idx, in_word};
         cache_wdata = DataIn;
      end else if (p2_v) begin
         cache_we    = 1'b1;
         cache_addr  = {req_idx, p2_word};
         cache_wdata = p2_data;
      end else if (fill_done && req_wr) begin
         cache_we    = 1'b1;
      end
   end

   // NOTE: storage arrays carry no reset; only valid/dirty need clearing to invalidate lines.
   always_ff @(posedge clk) begin
      if (mem_we)   main_mem[mem_waddr] <= mem_wdata;
      if (cache_we) data_ram[cache_addr] <= cache_wdata;
      if (tag_we)   tag_ram[req_idx] <= req_tag;
      p1_data <= main_mem[mem_raddr];
      p1_word <= cnt;
      p2_data <= p1_data;
      p2_word <= p1_word;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         valid    <= '0;
         dirty    <= '0;
         Done     <= 1'b0;
         Stall    <= 1'b0;
         CacheHit <= 1'b0;
         DataOut  <= '0;
         cnt      <= '0;
         p1_v     <= 1'b0;
         p2_v     <= 1'b0;
         req_tag  <= '0;
         req_idx  <= '0;
         req_word <= '0;
         req_data <= '0;
         req_wr   <= 1'b0;
      end else begin
         Done     <= 1'b0;
         CacheHit <= 1'b0;
         DataOut  <= '0;
         p1_v     <= 1'b0;
         p2_v     <= p1_v;
         case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               Stall <= 1'b0;
               if (accept) begin
                  req_tag  <= in_tag;
                  req_idx  <= in_idx;
                  req_word <= in_word;
                  req_data <= DataIn;
                  req_wr   <= Wr;
                  cnt      <= '0;
                  if (lookup_hit) begin
                     state    <= S_DONE;
                     Done     <= 1'b1;
                     CacheHit <= 1'b1;
                     DataOut  <= Wr ? DataIn : lookup_word;
                     if (Wr) dirty[in_idx] <= 1'b1;
                  end else begin
                     Stall <= 1'b1;
                     state <= (valid[in_idx] && dirty[in_idx]) ? S_WRITEBACK : S_ALLOC;
                  end
               end
            end
            S_WRITEBACK: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) state <= S_ALLOC;
            end
            S_ALLOC: begin
               p1_v <= 1'b1;
               cnt  <= cnt + 2'd1;
               if (cnt == 2'd3) state <= S_ALLOC_WAIT;
            end
            S_ALLOC_WAIT: begin
               if (fill_done) begin
                  valid[req_idx] <= 1'b1;
                  dirty[req_idx] <= req_wr;
                  Done    <= 1'b1;
                  Stall   <= 1'b0;
                  DataOut <= req_wr ? req_data : data_ram[{req_idx, req_word}];
                  state   <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_mem_system.sv
// Directed and random checks of dm_cache_mem_system against a flat word-memory model.
module tb_dm_cache_mem_system;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Addr, DataIn;
   logic        Rd, Wr, createdump;
   logic [15:0] DataOut;
   logic        Done, Stall, CacheHit, err;

   int checks = 0;
   int errors = 0;
   logic [15:0] model [0:32767];

   dm_cache_mem_system dut (
      .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
      .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
      .CacheHit(CacheHit), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one request at a negedge, wait for Done (bounded), release it.
   task automatic do_req(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, output int lat, output logic hit,
                         output logic [15:0] dout);
      logic seen, stall_ok;
      Rd = ~wr; Wr = wr; Addr = addr; DataIn = data;
      seen = 1'b0; stall_ok = 1'b1; lat = 0; hit = 1'b0; dout = '0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (Done) begin
            seen = 1'b1;
            hit  = CacheHit;
            dout = DataOut;
            if (Stall) stall_ok = 1'b0;
         end else if (!Stall) begin
            stall_ok = 1'b0;
         end
      end
      Rd = 1'b0; Wr = 1'b0;
      check({tag, "_done"}, seen, 1);
      check({tag, "_stall"}, stall_ok, 1);
   endtask

   // exp_hit: 1 = must hit with latency 1, 0 = must miss, -1 = either.
   task automatic txn(input string tag, input logic wr, input logic [15:0] addr,
                      input logic [15:0] data, input int exp_hit);
      int lat;
      logic hit;
      logic [15:0] dout;
      do_req(tag, wr, addr, data, lat, hit, dout);
      if (exp_hit >= 0) check({tag, "_hit"}, hit, exp_hit[0]);
      if (exp_hit == 1) check({tag, "_lat1"}, lat, 1);
      if (hit) check({tag, "_hitlat"}, lat <= 2, 1);
      else     check({tag, "_misslat"}, (lat >= 3) && (lat <= 20), 1);
      if (!wr) check({tag, "_data"}, dout, model[addr[15:1]]);
      else     model[addr[15:1]] = data;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) model[i] = '0;
      rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; createdump = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_done", Done, 0);
      check("rst_stall", Stall, 0);
      check("rst_hit", CacheHit, 0);
      check("rst_dout", DataOut, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_done", Done, 0);

      txn("rd6000", 1'b0, 16'h6000, 16'h0000, 0);
      check("rd6000_const", model[16'h6000 >> 1], 16'h0000);
      txn("wr6002", 1'b1, 16'h6002, 16'hBEEF, 1);
      txn("rd6002", 1'b0, 16'h6002, 16'h0000, 1);
      txn("rdE002", 1'b0, 16'hE002, 16'h0000, 0);
      txn("rd6002_wb", 1'b0, 16'h6002, 16'h0000, 0);

      // Illegal requests: err raised, no Done, cache untouched.
      Rd = 1'b1; Wr = 1'b1; Addr = 16'h6004; DataIn = 16'h1234;
      #1 check("err_rdwr", err, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("err_rdwr_nodone", Done, 0);
      end
      Rd = 1'b0; Wr = 1'b0;
      #1 check("err_clear", err, 0);
      Rd = 1'b1; Addr = 16'h6001;
      #1 check("err_odd", err, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("err_odd_nodone", Done, 0);
      end
      Rd = 1'b0;
      @(negedge clk);
      txn("rd6004", 1'b0, 16'h6004, 16'h0000, 1);
      txn("rd6000_hit", 1'b0, 16'h6000, 16'h0000, 1);

      // Reset in the middle of a clean miss fill.
      Rd = 1'b1; Addr = 16'hE002;
      repeat (3) @(negedge clk);
      Rd = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("midrst_done", Done, 0);
      check("midrst_stall", Stall, 0);
      check("midrst_dout", DataOut, 0);
      rst = 1'b0;
      @(negedge clk);
      txn("post_rst_rd6002", 1'b0, 16'h6002, 16'h0000, 0);

      txn("wr_miss_1236", 1'b1, 16'h1236, 16'hA5A5, 0);
      txn("rd_1236", 1'b0, 16'h1236, 16'h0000, 1);
      txn("wr_miss_9236", 1'b1, 16'h9236, 16'h5A5A, 0);
      txn("rd_1236_wb", 1'b0, 16'h1236, 16'h0000, 0);
      txn("rd_9236", 1'b0, 16'h9236, 16'h0000, 0);

      for (int i = 0; i < 100; i++) begin
         logic [15:0] a;
         logic [15:0] d;
         logic        w;
         a = 16'($urandom) & 16'hFFFE;
         if (i < 50) a = (a & 16'h07FE) | 16'h6000;
         d = 16'($urandom);
         w = 1'($urandom_range(0, 1));
         txn("rand", w, a, d, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
